// File: rtl/dmem_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache behind the LSQ dmem port.
// One request in flight at a time; lines refill one word per memory handshake.
module dmem_responder #(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic        dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int IDX_LO = OFF_W + 2;
  localparam int TAG_LO = IDX_LO + IDX_W;
  localparam int TAG_W  = 32 - TAG_LO;

  typedef enum logic [2:0] {IDLE, COMPARE, REFILL, WRITE_THRU, ST_DONE} state_e;

  state_e           state_q;
  logic [31:2]      req_addr_q;
  logic [3:0]       req_wmask_q;
  logic [31:0]      req_wdata_q;
  logic             req_is_store_q;
  logic [OFF_W-1:0] beat_q;
  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS][LINE_WORDS];

  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] word;
  logic [TAG_W-1:0] req_tag;
  logic             hit;
  logic             last_beat;
  logic [31:0]      merge_word;
  logic             unused_addr_bits;

  // Byte offset within a word never selects anything; the requester shifts loads.
  assign unused_addr_bits = ^dmem_addr[1:0];

  assign idx       = req_addr_q[TAG_LO-1:IDX_LO];
  assign word      = req_addr_q[IDX_LO-1:2];
  assign req_tag   = req_addr_q[31:TAG_LO];
  assign hit       = valid_q[idx] && (tag_q[idx] == req_tag);
  assign last_beat = (beat_q == OFF_W'(LINE_WORDS - 1));

  always_comb begin
    merge_word = data_q[idx][word];
    for (int b = 0; b < 4; b++) begin
      if (req_wmask_q[b]) merge_word[8*b +: 8] = req_wdata_q[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      req_addr_q     <= '0;
      req_wmask_q    <= '0;
      req_wdata_q    <= '0;
      req_is_store_q <= 1'b0;
      beat_q         <= '0;
      valid_q        <= '0;
      for (int s = 0; s < SETS; s++) tag_q[s] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if ((dmem_wmask != 4'b0000) || dmem_rmask) begin
            req_addr_q     <= dmem_addr[31:2];
            req_wmask_q    <= dmem_wmask;
            req_wdata_q    <= dmem_wdata;
            req_is_store_q <= (dmem_wmask != 4'b0000);
            state_q        <= COMPARE;
          end
        end
        COMPARE: begin
          if (req_is_store_q) begin
            state_q <= WRITE_THRU;
          end else if (hit) begin
            state_q <= IDLE;
          end else begin
            valid_q[idx] <= 1'b0;
            beat_q       <= '0;
            state_q      <= REFILL;
          end
        end
        REFILL: begin
          if (mem_resp) begin
            beat_q <= beat_q + 1'b1;
            if (last_beat) begin
              tag_q[idx]   <= req_tag;
              valid_q[idx] <= 1'b1;
              state_q      <= COMPARE;
            end
          end
        end
        WRITE_THRU: begin
          if (mem_resp) state_q <= ST_DONE;
        end
        ST_DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line storage carries no reset; valid_q alone decides whether it is meaningful.
  always_ff @(posedge clk) begin
    if (state_q == REFILL && mem_resp) begin
      data_q[idx][beat_q] <= mem_rdata;
    end else if (state_q == COMPARE && req_is_store_q && hit) begin
      data_q[idx][word] <= merge_word;
    end
  end

  always_comb begin
    dmem_resp  = 1'b0;
    dmem_rdata = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wmask  = '0;
    mem_wdata  = '0;
    case (state_q)
      COMPARE: begin
        if (!req_is_store_q && hit) begin
          dmem_resp  = 1'b1;
          dmem_rdata = data_q[idx][word];
        end
      end
      REFILL: begin
        mem_read = 1'b1;
        mem_addr = {req_addr_q[31:IDX_LO], beat_q, 2'b00};
      end
      WRITE_THRU: begin
        mem_write = 1'b1;
        mem_addr  = {req_addr_q, 2'b00};
        mem_wmask = req_wmask_q;
        mem_wdata = req_wdata_q;
      end
      ST_DONE: dmem_resp = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, multi-cycle corner sequences,
// then randomized traffic checked against a line-residency and backing-memory model.
module tb_dmem_responder;
  localparam int LW = 4;

  logic        clk;
  logic        rst;
  logic [31:0] dmem_addr;
  logic        dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  dmem_responder #(.SETS(16), .LINE_WORDS(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .dmem_addr  (dmem_addr),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_wmask  (mem_wmask),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory slave: word at address A defaults to A ^ 0xA5A5_0000, mem_waits wait cycles per beat.
  logic [31:0] mem_arr [0:4095];
  int unsigned mem_waits;
  int unsigned wcnt;

  initial begin
    for (int i = 0; i < 4096; i++) mem_arr[i] = (32'(i) << 2) ^ 32'hA5A5_0000;
  end

  assign mem_resp  = (mem_read | mem_write) && (wcnt == mem_waits);
  assign mem_rdata = mem_arr[mem_addr[13:2]];

  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if ((mem_read | mem_write) && !mem_resp) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(posedge clk) begin
    if (!rst && mem_write && mem_resp) begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem_arr[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // Reference model: which line address lives in each set, plus the expected memory image.
  logic [31:0] ref_mem [0:4095];
  bit          res_valid [16];
  logic [27:0] res_line  [16];

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = (32'(i) << 2) ^ 32'hA5A5_0000;
  end

  int checks;
  int errors;
  int txn_no;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h required %08h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 16; s++) res_valid[s] = 1'b0;
  endtask

  task automatic model_apply(input logic [31:0] a, input logic [3:0] wm, input logic [31:0] wd,
                             output int lat, output logic [31:0] rd);
    int set;
    int wi;
    logic [27:0] line;
    line = a[31:4];
    set  = int'((a >> 4) % 16);
    wi   = int'((a >> 2) % 4096);
    if (wm != 4'b0000) begin
      lat = int'(mem_waits) + 3;
      rd  = 32'h0;
      for (int b = 0; b < 4; b++)
        if (wm[b]) ref_mem[wi][8*b +: 8] = wd[8*b +: 8];
    end else begin
      if (res_valid[set] && res_line[set] == line) begin
        lat = 1;
      end else begin
        lat = 2 + LW * (int'(mem_waits) + 1);
        res_valid[set] = 1'b1;
        res_line[set]  = line;
      end
      rd = ref_mem[wi];
    end
  endtask

  // Issue one request at a negedge, follow it to dmem_resp, check every side effect.
  task automatic do_req(input logic [31:0] a, input logic rm, input logic [3:0] wm,
                        input logic [31:0] wd, input int exp_lat, input logic [31:0] exp_rd);
    int cyc;
    bit done;
    int both;
    int wcyc;
    int nwr;
    logic [31:0] rd_addrs[$];
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_mask;
    logic [31:0] got_rd;
    logic [31:0] base;
    bit is_store;
    is_store = (wm != 4'b0000);
    cyc = 0; done = 0; both = 0; wcyc = 0; nwr = 0;
    wr_addr = '0; wr_data = '0; wr_mask = '0; got_rd = '0;
    dmem_addr = a; dmem_rmask = rm; dmem_wmask = wm; dmem_wdata = wd;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (mem_read && mem_write) both++;
      if (mem_read && mem_resp) rd_addrs.push_back(mem_addr);
      if (mem_write) begin
        wcyc++;
        if (mem_resp) begin
          nwr++;
          wr_addr = mem_addr; wr_mask = mem_wmask; wr_data = mem_wdata;
        end
      end
      if (dmem_resp) begin
        done = 1;
        got_rd = dmem_rdata;
      end
    end
    dmem_addr = '0; dmem_rmask = 1'b0; dmem_wmask = '0; dmem_wdata = '0;
    txn_no++;
    $display("txn %0d addr=%08h rm=%0b wm=%b wd=%08h lat=%0d rdata=%08h", txn_no, a, rm, wm, wd, cyc, got_rd);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout txn %0d: got no dmem_resp in %0d cycles, required one at %0d", txn_no, cyc, exp_lat);
    end else begin
      chk("latency", 32'(cyc), 32'(exp_lat));
      chk("rdata", got_rd, exp_rd);
      base = {a[31:4], 4'b0000};
      if (is_store) begin
        chk("store_no_reads", 32'(rd_addrs.size()), 32'd0);
        chk("store_one_write", 32'(nwr), 32'd1);
        chk("write_addr", wr_addr, {a[31:2], 2'b00});
        chk("write_mask", 32'(wr_mask), 32'(wm));
        chk("write_data", wr_data, wd);
        chk("write_held_cycles", 32'(wcyc), 32'(mem_waits + 1));
      end else begin
        chk("load_no_writes", 32'(wcyc), 32'd0);
        chk("read_beats", 32'(rd_addrs.size()), (exp_lat == 1) ? 32'd0 : 32'(LW));
        for (int k = 0; k < rd_addrs.size() && k < LW; k++)
          chk("read_addr", rd_addrs[k], base + 32'(4 * k));
      end
    end
    chk("rd_wr_exclusive", 32'(both), 32'd0);
    @(negedge clk);
    chk("resp_single_pulse", 32'(dmem_resp), 32'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        rm;
    logic [3:0]  wm;
    logic [31:0] wd;
    int          lat;
    logic [31:0] rd;
  } vec_t;

  initial begin
    vec_t        vecs [10];
    int          lat;
    int          nrd;
    logic [31:0] rd;
    logic [31:0] a;
    logic        rm;
    logic [3:0]  wm;
    logic [31:0] wd;

    vecs[0] = '{32'h0000_1048, 1'b1, 4'b0000, 32'h0,          6, 32'hA5A5_1048};
    vecs[1] = '{32'h0000_1048, 1'b1, 4'b0000, 32'h0,          1, 32'hA5A5_1048};
    vecs[2] = '{32'h0000_1048, 1'b0, 4'b1100, 32'hBEEF_0000,  3, 32'h0};
    vecs[3] = '{32'h0000_1048, 1'b1, 4'b0000, 32'h0,          1, 32'hBEEF_1048};
    vecs[4] = '{32'h0000_2000, 1'b0, 4'b1111, 32'h1234_5678,  3, 32'h0};
    vecs[5] = '{32'h0000_2000, 1'b1, 4'b0000, 32'h0,          6, 32'h1234_5678};
    vecs[6] = '{32'h0000_1040, 1'b1, 4'b0000, 32'h0,          1, 32'hA5A5_1040};
    vecs[7] = '{32'h0000_1140, 1'b1, 4'b0000, 32'h0,          6, 32'hA5A5_1140};
    vecs[8] = '{32'h0000_1040, 1'b1, 4'b0000, 32'h0,          6, 32'hA5A5_1040};
    vecs[9] = '{32'h0000_104C, 1'b1, 4'b0000, 32'h0,          1, 32'hA5A5_104C};

    checks = 0; errors = 0; txn_no = 0;
    mem_waits = 0;
    rst = 1'b1;
    dmem_addr = '0; dmem_rmask = 1'b0; dmem_wmask = '0; dmem_wdata = '0;
    model_clear();

    repeat (3) @(negedge clk);
    chk("rst_dmem_resp",  32'(dmem_resp), 32'd0);
    chk("rst_dmem_rdata", dmem_rdata, 32'd0);
    chk("rst_mem_read",   32'(mem_read), 32'd0);
    chk("rst_mem_write",  32'(mem_write), 32'd0);
    chk("rst_mem_addr",   mem_addr, 32'd0);
    chk("rst_mem_wmask",  32'(mem_wmask), 32'd0);
    chk("rst_mem_wdata",  mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      model_apply(vecs[v].addr, vecs[v].wm, vecs[v].wd, lat, rd);
      do_req(vecs[v].addr, vecs[v].rm, vecs[v].wm, vecs[v].wd, vecs[v].lat, vecs[v].rd);
    end

    // Slow memory, request carrying both rmask and wmask: must behave as a store.
    mem_waits = 3;
    model_apply(32'h0000_1044, 4'b0001, 32'h0000_00AA, lat, rd);
    do_req(32'h0000_1044, 1'b1, 4'b0001, 32'h0000_00AA, 6, 32'h0);
    model_apply(32'h0000_1044, 4'b0000, 32'h0, lat, rd);
    do_req(32'h0000_1044, 1'b1, 4'b0000, 32'h0, 1, 32'hA5A5_10AA);

    // Reset in the middle of a refill, after beat 1 has completed.
    mem_waits = 0;
    dmem_addr = 32'h0000_3000; dmem_rmask = 1'b1; dmem_wmask = '0; dmem_wdata = '0;
    nrd = 0;
    for (int c = 0; c < 50 && nrd < 2; c++) begin
      @(negedge clk);
      if (mem_read && mem_resp) nrd++;
    end
    chk("refill_started", 32'(nrd), 32'd2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrefill_rst_mem_read", 32'(mem_read), 32'd0);
    chk("midrefill_rst_mem_addr", mem_addr, 32'd0);
    chk("midrefill_rst_resp",     32'(dmem_resp), 32'd0);
    dmem_addr = '0; dmem_rmask = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    chk("post_rst_idle_read", 32'(mem_read), 32'd0);
    model_apply(32'h0000_3000, 4'b0000, 32'h0, lat, rd);
    do_req(32'h0000_3000, 1'b1, 4'b0000, 32'h0, 6, 32'hA5A5_3000);

    // Randomized traffic over 4 sets x 4 tags so hits, conflicts and stores mix.
    for (int n = 0; n < 150; n++) begin
      mem_waits = $urandom_range(0, 2);
      a = 32'h0000_1000 + (32'($urandom_range(0, 3)) << 8) + (32'($urandom_range(0, 3)) << 4)
        + (32'($urandom_range(0, 3)) << 2) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 6) begin
        rm = 1'b1;
        wm = 4'b0000;
      end else begin
        rm = 1'($urandom_range(0, 1));
        wm = 4'($urandom_range(1, 15));
      end
      wd = $urandom;
      model_apply(a, wm, wd, lat, rd);
      do_req(a, rm, wm, wd, lat, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
